fft_test_sys_onchip_memory_dp: RTL and testbench

//  Parametrised true-dual-port on-chip RAM with two Avalon-MM slaves (s1 = port A, s2 = port B).

---
 rtl/fft_test_sys_onchip_memory_dp.sv | 141 ++++++++++++++
 tb/tb_fft_test_sys_onchip_memory_dp.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_test_sys_onchip_memory_dp.sv
// True-dual-port Avalon-MM on-chip RAM for the FFT test system.
// Port A (s1) serves the CPU, port B (s2) the FFT sample DMA.

module fft_test_sys_onchip_memory_dp #(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 32768,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "UNUSED",
    localparam int   ADDR_W       = $clog2(DEPTH),
    localparam int   NBE          = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_req,
    input  logic              clken,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              a_chipselect,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [NBE-1:0]    a_byteenable,
    input  logic [DATA_W-1:0] a_writedata,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,
    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_chipselect,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [NBE-1:0]    b_byteenable,
    input  logic [DATA_W-1:0] b_writedata,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,
    output logic              wr_err
);

    if (DATA_W % 8 != 0) begin : g_chk_w
        $error("DATA_W must be a multiple of 8");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_chk_lat
        $error("READ_LATENCY must be 1 or 2");
    end
    // Preload images are applied by the device memory-init flow.
    if (INIT_FILE != "UNUSED") begin : g_chk_init
        $warning("INIT_FILE is loaded by the memory-init flow, not RTL");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic ce;
    logic a_in, b_in;
    logic a_wr, b_wr, a_rd, b_rd;
    logic a_wok, b_wok, a_werr, b_werr;

    assign ce = clken & ~reset_req;

    if (DEPTH == (1 << ADDR_W)) begin : g_pow2
        assign a_in = 1'b1;
        assign b_in = 1'b1;
    end else begin : g_range
        localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
        assign a_in = {1'b0, a_address} < LIMIT;
        assign b_in = {1'b0, b_address} < LIMIT;
    end

    // A write on a port wins over a read on the same port.
    assign a_wr = ce & a_chipselect & a_write;
    assign b_wr = ce & b_chipselect & b_write;
    assign a_rd = ce & a_chipselect & a_read & ~a_write;
    assign b_rd = ce & b_chipselect & b_read & ~b_write;

    assign a_wok  = a_wr & ~freeze & a_in;
    assign b_wok  = b_wr & ~freeze & b_in;
    assign a_werr = a_wr & (|a_byteenable) & (freeze | ~a_in);
    assign b_werr = b_wr & (|b_byteenable) & (freeze | ~b_in);

    // A is applied last so its lanes take precedence on a shared word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBE; i++) begin
            if (b_wok && b_byteenable[i])
                mem[b_address][8*i +: 8] <= b_writedata[8*i +: 8];
            if (a_wok && a_byteenable[i])
                mem[a_address][8*i +: 8] <= a_writedata[8*i +: 8];
        end
    end

    logic              a_rv1, b_rv1;
    logic [DATA_W-1:0] a_rd1, b_rd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rv1 <= 1'b0;
            b_rv1 <= 1'b0;
            a_rd1 <= '0;
            b_rd1 <= '0;
        end else if (ce) begin
            a_rv1 <= a_rd;
            b_rv1 <= b_rd;
            if (a_rd)
                a_rd1 <= a_in ? mem[a_address] : '0;
            if (b_rd)
                b_rd1 <= b_in ? mem[b_address] : '0;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic              a_rv2, b_rv2;
        logic [DATA_W-1:0] a_rd2, b_rd2;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_rv2 <= 1'b0;
                b_rv2 <= 1'b0;
                a_rd2 <= '0;
                b_rd2 <= '0;
            end else if (ce) begin
                a_rv2 <= a_rv1;
                b_rv2 <= b_rv1;
                a_rd2 <= a_rd1;
                b_rd2 <= b_rd1;
            end
        end

        assign a_readdata      = a_rd2;
        assign b_readdata      = b_rd2;
        assign a_readdatavalid = a_rv2 & ce;
        assign b_readdatavalid = b_rv2 & ce;
    end else begin : g_lat1
        assign a_readdata      = a_rd1;
        assign b_readdata      = b_rd1;
        assign a_readdatavalid = a_rv1 & ce;
        assign b_readdatavalid = b_rv1 & ce;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wr_err <= 1'b0;
        else if (a_werr || b_werr)
            wr_err <= 1'b1;
    end

endmodule

// File: tb/tb_fft_test_sys_onchip_memory_dp.sv
// Randomised bench for the dual-port RAM against an array/queue model.
// Reads are predicted per accepted edge and matched against captured valids.

module tb_fft_test_sys_onchip_memory_dp;

    localparam int DW    = 32;
    localparam int DEPTH = 48;
    localparam int RL    = 2;
    localparam int AW    = 6;
    localparam int NB    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          reset_req, clken, freeze;
    logic [AW-1:0] a_address, b_address;
    logic          a_chipselect, a_read, a_write;
    logic          b_chipselect, b_read, b_write;
    logic [NB-1:0] a_byteenable, b_byteenable;
    logic [DW-1:0] a_writedata, b_writedata;
    logic [DW-1:0] a_readdata, b_readdata;
    logic          a_readdatavalid, b_readdatavalid;
    logic          wr_err;

    fft_test_sys_onchip_memory_dp #(
        .DATA_W(DW), .DEPTH(DEPTH), .READ_LATENCY(RL), .INIT_FILE("UNUSED")
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .freeze(freeze),
        .a_address(a_address), .a_chipselect(a_chipselect),
        .a_read(a_read), .a_write(a_write),
        .a_byteenable(a_byteenable), .a_writedata(a_writedata),
        .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_chipselect(b_chipselect),
        .b_read(b_read), .b_write(b_write),
        .b_byteenable(b_byteenable), .b_writedata(b_writedata),
        .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int ce_low_valids = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] a_exp[$], b_exp[$], a_got[$], b_got[$];
    logic          exp_err = 1'b0;

    always @(negedge clk) begin
        if (a_readdatavalid) a_got.push_back(a_readdata);
        if (b_readdatavalid) b_got.push_back(b_readdata);
        if ((a_readdatavalid || b_readdatavalid) && !(clken && !reset_req))
            ce_low_valids++;
    end

    initial begin
        #300000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_chipselect = 0; a_read = 0; a_write = 0;
        b_chipselect = 0; b_read = 0; b_write = 0;
        a_byteenable = '1; b_byteenable = '1;
    endtask

    task automatic clear_q();
        a_exp.delete(); b_exp.delete();
        a_got.delete(); b_got.delete();
    endtask

    // Predict the effect of the current inputs at the next edge, then clock.
    task automatic step();
        logic [DW-1:0] a_old, b_old;
        bit a_ok, b_ok;
        if (clken && !reset_req) begin
            a_ok  = int'(a_address) < DEPTH;
            b_ok  = int'(b_address) < DEPTH;
            a_old = a_ok ? model[a_address] : '0;
            b_old = b_ok ? model[b_address] : '0;
            if (a_chipselect && a_read && !a_write) a_exp.push_back(a_old);
            if (b_chipselect && b_read && !b_write) b_exp.push_back(b_old);
            for (int i = 0; i < NB; i++) begin
                if (b_chipselect && b_write && b_byteenable[i] && !freeze && b_ok)
                    model[b_address][8*i +: 8] = b_writedata[8*i +: 8];
                if (a_chipselect && a_write && a_byteenable[i] && !freeze && a_ok)
                    model[a_address][8*i +: 8] = a_writedata[8*i +: 8];
            end
            if (a_chipselect && a_write && (|a_byteenable) && (freeze || !a_ok))
                exp_err = 1'b1;
            if (b_chipselect && b_write && (|b_byteenable) && (freeze || !b_ok))
                exp_err = 1'b1;
        end
        tick();
    endtask

    task automatic drain();
        idle();
        clken = 1; reset_req = 0; freeze = 0;
        repeat (RL + 3) step();
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        clear_q();
        exp_err = 1'b0;
    endtask

    task automatic a_wr(int addr, logic [NB-1:0] be, logic [DW-1:0] d);
        a_chipselect = 1; a_write = 1; a_read = 0;
        a_address = AW'(addr); a_byteenable = be; a_writedata = d;
    endtask

    task automatic b_wr(int addr, logic [NB-1:0] be, logic [DW-1:0] d);
        b_chipselect = 1; b_write = 1; b_read = 0;
        b_address = AW'(addr); b_byteenable = be; b_writedata = d;
    endtask

    task automatic a_rq(int addr);
        a_chipselect = 1; a_read = 1; a_write = 0; a_address = AW'(addr);
    endtask

    task automatic b_rq(int addr);
        b_chipselect = 1; b_read = 1; b_write = 0; b_address = AW'(addr);
    endtask

    task automatic test_reset();
        reset = 1;
        #3;
        total++;
        if (a_readdata !== '0 || b_readdata !== '0)
            $display("FAIL rst_data a=%h b=%h exp 0", a_readdata, b_readdata);
        else passed++;
        total++;
        if (a_readdatavalid !== 1'b0 || b_readdatavalid !== 1'b0)
            $display("FAIL rst_valid a=%b b=%b exp 0", a_readdatavalid, b_readdatavalid);
        else passed++;
        total++;
        if (wr_err !== 1'b0) $display("FAIL rst_err got %b exp 0", wr_err);
        else passed++;
        tick();
        tick();
        reset = 0;
        step();
        total++;
        if (a_readdatavalid !== 1'b0 || wr_err !== 1'b0)
            $display("FAIL rst_release valid=%b err=%b exp 0", a_readdatavalid, wr_err);
        else passed++;
    endtask

    task automatic test_fill_readback();
        clear_q();
        for (int k = 0; k < DEPTH / 2; k++) begin
            a_wr(2 * k, '1, $urandom);
            b_wr(2 * k + 1, '1, $urandom);
            step();
        end
        idle();
        for (int k = 0; k < DEPTH; k++) begin
            a_rq(k);
            b_rq(DEPTH - 1 - k);
            step();
        end
        drain();
        total++;
        if (a_got.size() != DEPTH || b_got.size() != DEPTH)
            $display("FAIL fill_count a=%0d b=%0d exp %0d", a_got.size(), b_got.size(), DEPTH);
        else passed++;
        for (int k = 0; k < DEPTH && k < a_got.size() && k < b_got.size(); k++) begin
            total++;
            if (a_got[k] !== a_exp[k] || b_got[k] !== b_exp[k])
                $display("FAIL fill_data[%0d] a=%h/%h b=%h/%h", k, a_got[k], a_exp[k], b_got[k], b_exp[k]);
            else passed++;
        end
    endtask

    task automatic test_write_then_read();
        clear_q();
        a_wr(5, 4'b1111, 32'hDEADBEEF);
        step();
        idle();
        b_rq(5);
        step();
        idle();
        for (int k = 1; k < RL; k++) begin
            total++;
            if (b_readdatavalid !== 1'b0)
                $display("FAIL wr_rd_early valid=%b exp 0 at cycle %0d", b_readdatavalid, k);
            else passed++;
            step();
        end
        total++;
        if (b_readdatavalid !== 1'b1 || b_readdata !== 32'hDEADBEEF)
            $display("FAIL wr_rd valid=%b data=%h exp 1/deadbeef", b_readdatavalid, b_readdata);
        else passed++;
        drain();
        total++;
        if (b_got.size() != 1) $display("FAIL wr_rd_count got %0d exp 1", b_got.size());
        else passed++;
    endtask

    task automatic test_read_during_write();
        clear_q();
        a_wr(7, '1, 32'h11111111);
        step();
        idle();
        a_rq(7);
        b_wr(7, '1, 32'h22222222);
        step();
        idle();
        a_rq(7);
        step();
        drain();
        total++;
        if (a_got.size() != 2) $display("FAIL rdw_count got %0d exp 2", a_got.size());
        else passed++;
        if (a_got.size() == 2) begin
            total++;
            if (a_got[0] !== 32'h11111111) $display("FAIL rdw_old got %h exp 11111111", a_got[0]);
            else passed++;
            total++;
            if (a_got[1] !== 32'h22222222) $display("FAIL rdw_new got %h exp 22222222", a_got[1]);
            else passed++;
        end
    endtask

    task automatic test_dual_write();
        clear_q();
        a_wr(3, '1, 32'h0);
        step();
        a_wr(3, 4'b0011, 32'hAAAAAAAA);
        b_wr(3, 4'b0110, 32'hBBBBBBBB);
        step();
        idle();
        b_rq(3);
        step();
        drain();
        total++;
        if (b_got.size() != 1 || b_got[0] !== 32'h00BBAAAA)
            $display("FAIL dual_wr got %h (n=%0d) exp 00bbaaaa", b_got.size() ? b_got[0] : 'x, b_got.size());
        else passed++;
    endtask

    task automatic test_burst_ce();
        clear_q();
        ce_low_valids = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                clken = 0;
                repeat (3) begin
                    a_rq($urandom_range(0, DEPTH - 1));
                    step();
                end
                clken = 1;
            end
            a_rq($urandom_range(0, DEPTH - 1));
            step();
        end
        drain();
        total++;
        if (a_got.size() != 8 || a_exp.size() != 8)
            $display("FAIL burst_count got %0d exp 8", a_got.size());
        else passed++;
        for (int i = 0; i < a_got.size() && i < a_exp.size(); i++) begin
            total++;
            if (a_got[i] !== a_exp[i]) $display("FAIL burst[%0d] got %h exp %h", i, a_got[i], a_exp[i]);
            else passed++;
        end
        total++;
        if (ce_low_valids != 0) $display("FAIL burst_ce_low got %0d exp 0", ce_low_valids);
        else passed++;
    endtask

    task automatic test_random();
        clear_q();
        ce_low_valids = 0;
        for (int n = 0; n < 400; n++) begin
            clken = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            a_chipselect = ($urandom_range(0, 3) != 0);
            a_read = 1'($urandom);
            a_write = 1'($urandom);
            a_address = AW'($urandom_range(0, DEPTH + 3));
            a_byteenable = NB'($urandom);
            a_writedata = $urandom;
            b_chipselect = ($urandom_range(0, 3) != 0);
            b_read = 1'($urandom);
            b_write = 1'($urandom);
            b_address = ($urandom_range(0, 3) == 0) ? a_address : AW'($urandom_range(0, DEPTH + 3));
            b_byteenable = NB'($urandom);
            b_writedata = $urandom;
            step();
        end
        drain();
        total++;
        if (a_got.size() != a_exp.size() || b_got.size() != b_exp.size())
            $display("FAIL rand_count a=%0d/%0d b=%0d/%0d", a_got.size(), a_exp.size(), b_got.size(), b_exp.size());
        else passed++;
        for (int i = 0; i < a_got.size() && i < a_exp.size(); i++) begin
            total++;
            if (a_got[i] !== a_exp[i]) $display("FAIL rand_a[%0d] got %h exp %h", i, a_got[i], a_exp[i]);
            else passed++;
        end
        for (int i = 0; i < b_got.size() && i < b_exp.size(); i++) begin
            total++;
            if (b_got[i] !== b_exp[i]) $display("FAIL rand_b[%0d] got %h exp %h", i, b_got[i], b_exp[i]);
            else passed++;
        end
        total++;
        if (wr_err !== exp_err) $display("FAIL rand_err got %b exp %b", wr_err, exp_err);
        else passed++;
        total++;
        if (ce_low_valids != 0) $display("FAIL rand_ce_low got %0d exp 0", ce_low_valids);
        else passed++;
    endtask

    task automatic test_freeze();
        logic [DW-1:0] pre;
        do_reset();
        pre = $urandom;
        a_wr(9, '1, pre);
        step();
        idle();
        total++;
        if (wr_err !== 1'b0) $display("FAIL frz_pre_err got %b exp 0", wr_err);
        else passed++;
        freeze = 1;
        b_wr(9, '1, ~pre);
        step();
        idle();
        freeze = 0;
        total++;
        if (wr_err !== 1'b1) $display("FAIL frz_err got %b exp 1", wr_err);
        else passed++;
        repeat (4) step();
        total++;
        if (wr_err !== 1'b1) $display("FAIL frz_err_hold got %b exp 1", wr_err);
        else passed++;
        do_reset();
        total++;
        if (wr_err !== 1'b0) $display("FAIL frz_err_clr got %b exp 0", wr_err);
        else passed++;
        b_rq(9);
        step();
        drain();
        total++;
        if (b_got.size() != 1 || b_got[0] !== pre)
            $display("FAIL frz_mem got %h (n=%0d) exp %h", b_got.size() ? b_got[0] : 'x, b_got.size(), pre);
        else passed++;
    endtask

    task automatic test_out_of_range();
        do_reset();
        a_rq(50);
        b_wr(60, '1, 32'hCAFEF00D);
        step();
        drain();
        total++;
        if (a_got.size() != 1 || a_got[0] !== '0)
            $display("FAIL oor_read got %h (n=%0d) exp 0", a_got.size() ? a_got[0] : 'x, a_got.size());
        else passed++;
        total++;
        if (wr_err !== 1'b1) $display("FAIL oor_err got %b exp 1", wr_err);
        else passed++;
        do_reset();
    endtask

    task automatic test_reset_inflight();
        clear_q();
        a_rq(10);
        step();
        a_rq(11);
        step();
        idle();
        reset = 1;
        #1;
        total++;
        if (a_readdata !== '0 || b_readdata !== '0)
            $display("FAIL inflight_data a=%h b=%h exp 0", a_readdata, b_readdata);
        else passed++;
        total++;
        if (a_readdatavalid !== 1'b0) $display("FAIL inflight_valid got %b exp 0", a_readdatavalid);
        else passed++;
        tick();
        tick();
        reset = 0;
        drain();
        total++;
        if (a_got.size() != 0) $display("FAIL inflight_lost got %0d valids exp 0", a_got.size());
        else passed++;
    endtask

    initial begin
        clken = 1; reset_req = 0; freeze = 0;
        a_address = '0; b_address = '0;
        a_writedata = '0; b_writedata = '0;
        idle();
        #2;
        test_reset();
        test_fill_readback();
        test_write_then_read();
        test_read_during_write();
        test_dual_write();
        test_burst_ce();
        test_random();
        test_freeze();
        test_out_of_range();
        test_reset_inflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
